reg_file_mp: RTL and testbench

//   Parametrised multi-port register file; next generation of the 16x16 register bank.

---
 rtl/reg_file_mp_pkg.sv | 13 +
 rtl/reg_file_rd_port.sv | 47 ++++
 rtl/reg_file_mp.sv | 104 ++++++++++
 tb/tb_reg_file_mp.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: default widths and FSM state encoding.
package reg_file_mp_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int NUM_RD_DEF = 2;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_READY = 2'b01
  } state_e;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: write-first bypass, optional zero-register masking, data/valid flops.
module reg_file_rd_port
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] next_data;

  // Hardwired zero wins over bypass, bypass wins over stored contents.
  always_comb begin
    next_data = mem_data;
    if (ZERO_REG && (addr == '0)) begin
      next_data = '0;
    end else if (wr_en && (wr_addr == addr)) begin
      next_data = wr_data;
    end else begin
      next_data = mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= en;
      if (en) begin
        rd_data <= next_data;
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with post-reset clear sequencer and write-first read bypass.
// Optional build macro ZERO_REG_EN makes entry 0 a hardwired zero.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WEN,
  input  logic [ADDR_W-1:0]        AddrWrite,
  input  logic [DATA_W-1:0]        WrData,
  input  logic [NUM_RD-1:0]        RdEn,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
  output logic [NUM_RD*DATA_W-1:0] RdData,
  output logic [NUM_RD-1:0]        RdValid,
  output logic                     Ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  state_e            state;
  state_e            next_state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ready_int;
  logic              wr_fire;

  assign ready_int = (state == ST_READY);
  assign Ready     = ready_int;
  assign wr_fire   = WEN && ready_int && !RST && !(ZERO_REG && (AddrWrite == '0));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_CLEAR;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_CLEAR: begin
        if (clr_cnt == LAST_IDX) begin
          next_state = ST_READY;
        end else begin
          next_state = ST_CLEAR;
        end
      end
      ST_READY: next_state = ST_READY;
      default:  next_state = ST_CLEAR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Storage carries no reset so it can map onto RAM; the sequencer zeroes it instead.
  always_ff @(posedge CLK) begin
    if (!RST && (state == ST_CLEAR)) begin
      mem[clr_cnt] <= '0;
    end else if (wr_fire) begin
      mem[AddrWrite] <= WrData;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] port_addr;
    assign port_addr = RdAddr[p*ADDR_W +: ADDR_W];

    reg_file_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .clk      (CLK),
      .rst      (RST),
      .en       (RdEn[p] && ready_int),
      .addr     (port_addr),
      .mem_data (mem[port_addr]),
      .wr_en    (wr_fire),
      .wr_addr  (AddrWrite),
      .wr_data  (WrData),
      .rd_data  (RdData[p*DATA_W +: DATA_W]),
      .rd_valid (RdValid[p])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (default geometry 16x16, two read ports).
module tb_reg_file_mp;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WEN;
  logic [3:0]  AddrWrite;
  logic [15:0] WrData;
  logic [1:0]  RdEn;
  logic [7:0]  RdAddr;
  logic [31:0] RdData;
  logic [1:0]  RdValid;
  logic        Ready;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  logic [15:0] model [16];

  reg_file_mp dut (
    .CLK       (CLK),
    .RST       (RST),
    .WEN       (WEN),
    .AddrWrite (AddrWrite),
    .WrData    (WrData),
    .RdEn      (RdEn),
    .RdAddr    (RdAddr),
    .RdData    (RdData),
    .RdValid   (RdValid),
    .Ready     (Ready)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    WEN = 1'b1; AddrWrite = a; WrData = d;
    step();
    WEN = 1'b0;
`ifdef ZERO_REG_EN
    if (a != 4'd0) model[a] = d;
`else
    model[a] = d;
`endif
  endtask

  task automatic rd2(input string tag, input logic [3:0] a, input logic [3:0] b);
    RdEn = 2'b11; RdAddr = {b, a};
    step();
    RdEn = 2'b00;
    chk({tag, "_valid"}, {30'd0, RdValid}, {30'd0, 2'b11});
    if (RdValid[0]) chk({tag, "_p0"}, {16'd0, RdData[15:0]}, {16'd0, model[a]});
    if (RdValid[1]) chk({tag, "_p1"}, {16'd0, RdData[31:16]}, {16'd0, model[b]});
  endtask

  // Walk the 16 clear cycles; with junk set, hammer the ignored write/read inputs.
  task automatic clear_wait(input string tag, input bit junk);
    if (junk) begin
      WEN = 1'b1; AddrWrite = 4'd2; WrData = 16'hAAAA;
      RdEn = 2'b11; RdAddr = {4'd2, 4'd2};
    end
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_ready_low"}, {31'd0, Ready}, 32'd0);
      chk({tag, "_valid_low"}, {30'd0, RdValid}, 32'd0);
      step();
    end
    WEN = 1'b0; RdEn = 2'b00;
    chk({tag, "_ready_high"}, {31'd0, Ready}, 32'd1);
    chk({tag, "_valid_after"}, {30'd0, RdValid}, 32'd0);
    model_clear();
  endtask

  initial begin
    RST = 1'b1; WEN = 1'b0; AddrWrite = 4'd0; WrData = 16'h0000;
    RdEn = 2'b00; RdAddr = 8'h00;
    model_clear();

    // T1: reset, clear sequence, all entries read zero
    step(); step();
    chk("t1_rst_ready", {31'd0, Ready}, 32'd0);
    chk("t1_rst_valid", {30'd0, RdValid}, 32'd0);
    chk("t1_rst_data", RdData, 32'd0);
    RST = 1'b0;
    clear_wait("t1", 1'b0);
    for (int i = 0; i < 16; i += 2) rd2("t1_read", 4'(i), 4'(i + 1));

    // T2: write then read
    wr(4'd0, 16'd1); wr(4'd5, 16'd5); wr(4'd11, 16'd11); wr(4'd15, 16'd15);
    rd2("t2_rd_0_5", 4'd0, 4'd5);
    rd2("t2_rd_11_15", 4'd11, 4'd15);
    step();
    chk("t2_hold_valid", {30'd0, RdValid}, 32'd0);
    chk("t2_hold_data", RdData, {16'd15, 16'd11});

    // T3: same-cycle write/read bypass on both ports
    WEN = 1'b1; AddrWrite = 4'd7; WrData = 16'hBEEF;
    RdEn = 2'b11; RdAddr = {4'd7, 4'd7};
    step();
    WEN = 1'b0; RdEn = 2'b00;
    model[7] = 16'hBEEF;
    chk("t3_bypass_valid", {30'd0, RdValid}, {30'd0, 2'b11});
    chk("t3_bypass_data", RdData, {16'hBEEF, 16'hBEEF});
    rd2("t3_stored", 4'd7, 4'd5);

    // T6: entry 0 behaviour, plain write and bypass
    wr(4'd0, 16'h00FF);
    rd2("t6_r0", 4'd0, 4'd0);
    WEN = 1'b1; AddrWrite = 4'd0; WrData = 16'h1234;
    RdEn = 2'b11; RdAddr = 8'h00;
    step();
    WEN = 1'b0; RdEn = 2'b00;
`ifdef ZERO_REG_EN
    chk("t6_bypass_r0", RdData, 32'd0);
`else
    model[0] = 16'h1234;
    chk("t6_bypass_r0", RdData, {16'h1234, 16'h1234});
`endif
    rd2("t6_r0_after", 4'd0, 4'd7);

    // T4 + T5: reset mid-clear, ignored ops during the restarted clear
    wr(4'd3, 16'h1234);
    rd2("t4_pre", 4'd3, 4'd3);
    RST = 1'b1; step(); RST = 1'b0;
    chk("t4_rst_valid", {30'd0, RdValid}, 32'd0);
    chk("t4_rst_data", RdData, 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("t4_first_clear_ready", {31'd0, Ready}, 32'd0);
      step();
    end
    RST = 1'b1; step(); RST = 1'b0;
    clear_wait("t4t5", 1'b1);
    rd2("t4_r3_r2", 4'd3, 4'd2);
    rd2("t4_r7_r15", 4'd7, 4'd15);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
